// File: rtl/expand_srange_stream.sv
`default_nettype none
// ============================================================================
// Module      : expand_srange_stream
// Description : Unpacks narrow signed lanes from packed words, sign-extends
//               and left-shifts each to OUTW bits, one sample per clock.
//               EXPAND_SCALE_SAT_EN selects saturation instead of wrap.
// Revision    : 1.0
// ============================================================================
module expand_srange_stream #(
    parameter int INW   = 8,
    parameter int OUTW  = 16,
    parameter int LANES = 4,
    parameter int LW    = 2
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_wordValid,
    output logic                   o_wordReady,
    input  logic [LANES*INW-1:0]   i_word,
    input  logic [LW:0]            i_validLanes,
    input  logic                   i_lastWord,
    input  logic [3:0]             i_shift,
    output logic                   o_sampleValid,
    input  logic                   i_sampleReady,
    output logic [OUTW-1:0]        o_sample,
    output logic                   o_sampleLast
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LW-1:0] c_idxOne = LW'(1);
    localparam logic [LW:0]   c_cntOne = (LW + 1)'(1);
    localparam logic [LW:0]   c_lanes  = (LW + 1)'(LANES);

    state_t                 r_state;
    logic [LANES*INW-1:0]   r_word;
    logic [LW:0]            r_count;
    logic                   r_last;
    logic [3:0]             r_shift;
    logic [LW-1:0]          r_idx;

    logic                   w_outAdvance;
    logic                   w_load;
    logic                   w_lastLane;
    logic                   w_wordXfer;
    logic [INW-1:0]         w_lane;
    logic [OUTW-1:0]        w_reduced;

    assign w_outAdvance = !o_sampleValid || i_sampleReady;
    assign w_load       = (r_state == HOLD) && w_outAdvance;
    assign w_lastLane   = ({1'b0, r_idx} == (r_count - c_cntOne));
    assign o_wordReady  = (r_state == EMPTY) || (w_load && w_lastLane);
    assign w_wordXfer   = i_wordValid && o_wordReady;
    assign w_lane       = r_word[int'(r_idx) * INW +: INW];

`ifdef EXPAND_SCALE_SAT_EN
    localparam int c_extW = OUTW + 15;
    localparam logic [OUTW-1:0] c_max = {1'b0, {(OUTW-1){1'b1}}};
    localparam logic [OUTW-1:0] c_min = {1'b1, {(OUTW-1){1'b0}}};

    logic signed [c_extW-1:0] w_ext;
    logic signed [c_extW-1:0] w_shifted;
    logic [c_extW-OUTW:0]     w_hi;

    assign w_ext     = c_extW'($signed(w_lane));
    assign w_shifted = w_ext <<< r_shift;
    assign w_hi      = w_shifted[c_extW-1:OUTW-1];

    // Representable only when every bit above the OUTW sign bit matches it.
    always_comb begin
        w_reduced = w_shifted[OUTW-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_reduced = w_shifted[c_extW-1] ? c_min : c_max;
        end
    end
`else
    // Low OUTW bits of the wide shift equal a shift done at OUTW width.
    logic signed [OUTW-1:0] w_extN;

    assign w_extN    = OUTW'($signed(w_lane));
    assign w_reduced = w_extN <<< r_shift;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state       <= EMPTY;
            r_word        <= '0;
            r_count       <= '0;
            r_last        <= 1'b0;
            r_shift       <= '0;
            r_idx         <= '0;
            o_sampleValid <= 1'b0;
            o_sample      <= '0;
            o_sampleLast  <= 1'b0;
        end else begin
            if (w_load) begin
                o_sampleValid <= 1'b1;
                o_sample      <= w_reduced;
                o_sampleLast  <= r_last && w_lastLane;
                r_idx         <= r_idx + c_idxOne;
            end else if (w_outAdvance) begin
                o_sampleValid <= 1'b0;
            end

            if (w_wordXfer) begin
                r_state <= HOLD;
                r_word  <= i_word;
                r_count <= (i_validLanes == '0) ? c_lanes : i_validLanes;
                r_last  <= i_lastWord;
                r_shift <= i_shift;
                r_idx   <= '0;
            end else if (w_load && w_lastLane) begin
                r_state <= EMPTY;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expand_srange_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_expand_srange_stream
// Description : Scoreboard bench for expand_srange_stream with directed and
//               randomized words checked against an arithmetic model.
// Revision    : 1.0
// ============================================================================
module tb_expand_srange_stream;

    localparam int INW   = 8;
    localparam int OUTW  = 16;
    localparam int LANES = 4;
    localparam int LW    = 2;

    logic                 clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_wordValid = 1'b0;
    logic                 o_wordReady;
    logic [LANES*INW-1:0] i_word = '0;
    logic [LW:0]          i_validLanes = '0;
    logic                 i_lastWord = 1'b0;
    logic [3:0]           i_shift = '0;
    logic                 o_sampleValid;
    logic                 i_sampleReady = 1'b0;
    logic [OUTW-1:0]      o_sample;
    logic                 o_sampleLast;

    expand_srange_stream #(.INW(INW), .OUTW(OUTW), .LANES(LANES), .LW(LW)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_wordValid(i_wordValid), .o_wordReady(o_wordReady),
        .i_word(i_word), .i_validLanes(i_validLanes),
        .i_lastWord(i_lastWord), .i_shift(i_shift),
        .o_sampleValid(o_sampleValid), .i_sampleReady(i_sampleReady),
        .o_sample(o_sample), .o_sampleLast(o_sampleLast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUTW-1:0] s;
        logic            l;
    } exp_t;

    exp_t sbQ[$];
    int   xferCyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    bit   rdyRandom = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Value of lane * 2^shift, reduced to OUTW by wrap or clamp.
    function automatic logic [OUTW-1:0] refExpand(input logic [INW-1:0] lane, input int sh);
        longint v;
        v = longint'($signed(lane)) * (longint'(1) << sh);
`ifdef EXPAND_SCALE_SAT_EN
        if (v > longint'((1 << (OUTW - 1)) - 1)) v = longint'((1 << (OUTW - 1)) - 1);
        if (v < -longint'(1 << (OUTW - 1)))      v = -longint'(1 << (OUTW - 1));
`endif
        return v[OUTW-1:0];
    endfunction

    task automatic pushWord(input logic [LANES*INW-1:0] w, input int vl, input bit last, input int sh);
        int   n;
        exp_t e;
        n = (vl == 0) ? LANES : vl;
        for (int k = 0; k < n; k++) begin
            e.s = refExpand(w[k*INW +: INW], sh);
            e.l = last && (k == n - 1);
            sbQ.push_back(e);
        end
    endtask

    // Leaves the word presented; a following sendWord or idle replaces it.
    task automatic sendWord(input logic [LANES*INW-1:0] w, input int vl, input bit last, input int sh);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        i_wordValid  = 1'b1;
        i_word       = w;
        i_validLanes = (LW + 1)'(vl);
        i_lastWord   = last;
        i_shift      = 4'(sh);
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (o_wordReady) begin
                pushWord(w, vl, last, sh);
                acceptCyc = cyc;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check("word_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            i_wordValid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !o_sampleValid) done = 1'b1;
        end
        if (!done) check("drain_timeout", sbQ.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!i_rst && o_sampleValid && i_sampleReady) begin
            xferCyc.push_back(cyc);
            if (sbQ.size() == 0) begin
                check("unexpected_sample", {16'd0, o_sample}, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                check("sample", {16'd0, o_sample}, {16'd0, e.s});
                check("sample_last", {31'd0, o_sampleLast}, {31'd0, e.l});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdyRandom) i_sampleReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int a1;
        int n;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, o_sampleValid}, 32'd0);
        check("rst_sample", {16'd0, o_sample}, 32'd0);
        check("rst_last", {31'd0, o_sampleLast}, 32'd0);
        check("rst_wordReady", {31'd0, o_wordReady}, 32'd1);

        // Single word, shift 0, latency one cycle.
        i_sampleReady = 1'b1;
        sendWord(32'h807F_01FF, 4, 1'b0, 0);
        idle(1);
        @(negedge clk);
        check("lat_not_yet", {31'd0, o_sampleValid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'd0, o_sampleValid}, 32'd1);
        check("lat_lane0", {16'd0, o_sample}, 32'h0000_FFFF);
        drain();

        // Back-to-back words, no bubble.
        sendWord(32'h1122_3344, 4, 1'b1, 1);
        a1 = acceptCyc;
        sendWord(32'hF0E1_D2C3, 4, 1'b1, 2);
        check("b2b_accept_gap", acceptCyc - a1, 32'd4);
        idle(1);
        drain();
        n = xferCyc.size();
        check("b2b_no_bubble", xferCyc[n-1] - xferCyc[n-8], 32'd7);

        // Partial word.
        sendWord(32'hAAAA_0302, 2, 1'b1, 0);
        idle(1);
        drain();

        // Output stall.
        @(posedge clk); #1 i_sampleReady = 1'b0;
        sendWord(32'h5566_7788, 4, 1'b0, 3);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, o_sampleValid}, 32'd1);
            check("stall_hold", {16'd0, o_sample}, {16'd0, sbQ[0].s});
            check("stall_wordReady", {31'd0, o_wordReady}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 i_sampleReady = 1'b1;
        drain();

        // Overflow of 7F and 80 at shift 9.
        sendWord(32'h0000_807F, 2, 1'b0, 9);
        idle(1);
        drain();

        // Reset mid-word.
        @(posedge clk); #1 i_sampleReady = 1'b0;
        sendWord(32'h0403_0201, 4, 1'b0, 0);
        idle(3);
        @(posedge clk); #1 i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        sbQ.delete();
        @(negedge clk);
        check("midrst_valid", {31'd0, o_sampleValid}, 32'd0);
        check("midrst_wordReady", {31'd0, o_wordReady}, 32'd1);
        @(posedge clk); #1 i_sampleReady = 1'b1;
        sendWord(32'h4433_2211, 4, 1'b1, 0);
        idle(1);
        drain();

        // Randomized traffic with random backpressure.
        rdyRandom = 1'b1;
        for (int w = 0; w < 60; w++) begin
            sendWord($urandom, $urandom_range(0, LANES), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        @(negedge clk);
        rdyRandom = 1'b0;
        @(posedge clk); #1 i_sampleReady = 1'b1;
        drain();
        check("final_queue_empty", sbQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
